alu_multicycle: RTL and testbench

//   Parametrised multi-cycle integer ALU for the Y86-64 execute stage; successor to the

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_slice.sv | 31 +++
 rtl/alu_multicycle.sv | 142 ++++++++++++++
 tb/tb_alu_multicycle.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: function codes, FSM states, CC bit positions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

  typedef enum logic [1:0] {
    FUN_ADD = 2'b00,
    FUN_SUB = 2'b01,
    FUN_AND = 2'b10,
    FUN_XOR = 2'b11
  } fun_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Bit positions inside cc = {ZF,SF,OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

endpackage

// File: rtl/alu_slice.sv
// One CHUNK-bit ALU slice: add-with-carry (ADD/SUB), AND, XOR selected by fun_i.
// Latency: combinational.
// Backpressure: none; the caller sequences slices.
// Ports: fun_i function code, a_i/b_i slice operands (b_i already inverted for SUB),
//        cin_i carry-in, y_o slice result, cout_o carry-out (0 for logic ops).
module alu_slice
  import alu_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  logic [1:0]       fun_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] y_o,
  output logic             cout_o
);

  always_comb begin
    y_o    = '0;
    cout_o = 1'b0;
    case (fun_e'(fun_i))
      // SUB arrives here as a + ~b + 1, so it shares the adder with ADD.
      FUN_ADD, FUN_SUB: {cout_o, y_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
      FUN_AND:          y_o = a_i & b_i;
      FUN_XOR:          y_o = a_i ^ b_i;
      default:          y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ADD/SUB/AND/XOR ALU with {ZF,SF,OF} condition codes, CHUNK bits per cycle.
// Latency: out_valid rises WIDTH/CHUNK edges after the accept edge.
// Backpressure: result/cc held in DONE until out_ready; in_ready low outside IDLE.
// Ports: clk, rst_n (async low); in_valid/in_ready/fun/a/b request side;
//        out_valid/out_ready/result/cc response side.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       cc
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("alu_multicycle: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic             a_msb_q, b_msb_q;   // operand signs kept aside since a_q/b_q shift
  logic [1:0]       fun_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       cc_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] slice_y;
  logic             slice_cout;
  logic [WIDTH-1:0] a_shift, b_shift, res_d;
  logic [2:0]       cc_d;
  logic             last_slice;

  // The low CHUNK bits of a_q/b_q are always the slice being worked on.
  alu_slice #(.CHUNK(CHUNK)) u_slice (
    .fun_i  (fun_q),
    .a_i    (a_q[CHUNK-1:0]),
    .b_i    (b_q[CHUNK-1:0]),
    .cin_i  (carry_q),
    .y_o    (slice_y),
    .cout_o (slice_cout)
  );

  // Operands shift right one slice per cycle; results shift in from the top, so after
  // N cycles acc holds the full word in order.
  generate
    if (N == 1) begin : g_single
      assign a_shift = a_q;
      assign b_shift = b_q;
      assign res_d   = slice_y;
    end else begin : g_multi
      assign a_shift = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
      assign b_shift = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
      assign res_d   = {slice_y, acc_q[WIDTH-1:CHUNK]};
    end
  endgenerate

  assign last_slice = (count_q == CW'(N - 1));

  // b_msb_q is post-inversion, so "same signs" covers both ADD and SUB overflow.
  always_comb begin
    cc_d        = 3'b000;
    cc_d[CC_ZF] = (res_d == '0);
    cc_d[CC_SF] = res_d[WIDTH-1];
    cc_d[CC_OF] = (fun_q == FUN_ADD || fun_q == FUN_SUB) &&
                  (a_msb_q == b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      fun_q       <= 2'b00;
      carry_q     <= 1'b0;
      result_q    <= '0;
      cc_q        <= 3'b000;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= (fun == FUN_SUB) ? ~b : b;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= (fun == FUN_SUB) ? ~b[WIDTH-1] : b[WIDTH-1];
            fun_q   <= fun;
            carry_q <= (fun == FUN_SUB);
            count_q <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          a_q     <= a_shift;
          b_q     <= b_shift;
          acc_q   <= res_d;
          carry_q <= slice_cout;
          count_q <= count_q + CW'(1);
          if (last_slice) begin
            result_q    <= res_d;
            cc_q        <= cc_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: CHUNK=16 and CHUNK=64 instances driven in lockstep.
// A reference model predicts result/cc and latency; directed vectors pin literal values.
module tb_alu_multicycle;

  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, out_ready;
  logic [1:0]   fun;
  logic [W-1:0] a, b;
  logic [1:0]   in_ready_v, out_valid_v;
  logic [W-1:0] result_v [2];
  logic [2:0]   cc_v [2];

  alu_multicycle #(.WIDTH(64), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .fun(fun), .a(a), .b(b), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .result(result_v[0]), .cc(cc_v[0]));

  alu_multicycle #(.WIDTH(64), .CHUNK(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .fun(fun), .a(a), .b(b), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .result(result_v[1]), .cc(cc_v[1]));

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  bit          pending [2];
  bit          seen [2];
  logic [66:0] exp_v [2];
  int          acc_edge [2];
  int          lat [2] = '{4, 1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Reference: signed arithmetic one bit wider, overflow when the wide result
  // does not fit back into 64 bits. Returns {result, ZF, SF, OF}.
  function automatic logic [66:0] model(input logic [1:0] f, input logic [63:0] x, input logic [63:0] y);
    logic signed [64:0] wide;
    logic [63:0] r;
    logic of;
    wide = '0;
    of   = 1'b0;
    case (f)
      2'b00: begin wide = $signed({x[63], x}) + $signed({y[63], y}); r = wide[63:0]; of = wide[64] != wide[63]; end
      2'b01: begin wide = $signed({x[63], x}) - $signed({y[63], y}); r = wide[63:0]; of = wide[64] != wide[63]; end
      2'b10: r = x & y;
      default: r = x ^ y;
    endcase
    return {r, (r == 64'd0), r[63], of};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the model for both instances.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        pending[d] = 1'b0;
        check($sformatf("rst_out_valid%0d", d), 64'(out_valid_v[d]), 64'd0);
        check($sformatf("rst_result%0d", d), result_v[d], 64'd0);
        check($sformatf("rst_cc%0d", d), 64'(cc_v[d]), 64'd0);
      end else begin
        if (out_valid_v[d]) begin
          if (!pending[d]) begin
            check($sformatf("valid_without_op%0d", d), 64'(out_valid_v[d]), 64'd0);
          end else begin
            check($sformatf("result%0d", d), result_v[d], exp_v[d][66:3]);
            check($sformatf("cc%0d", d), 64'(cc_v[d]), 64'(exp_v[d][2:0]));
            check($sformatf("in_ready_done%0d", d), 64'(in_ready_v[d]), 64'd0);
            if (!seen[d]) begin
              check($sformatf("latency%0d", d), 64'(cyc - acc_edge[d]), 64'(lat[d]));
              seen[d] = 1'b1;
            end
            if (out_ready) pending[d] = 1'b0;
          end
        end
        if (in_valid && in_ready_v[d]) begin
          pending[d]  = 1'b1;
          seen[d]     = 1'b0;
          exp_v[d]    = model(fun, a, b);
          acc_edge[d] = cyc + 1;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] f, input logic [63:0] x, input logic [63:0] y);
    int t;
    t = 0;
    while (in_ready_v != 2'b11 && t < 20) begin @(posedge clk); #1; t++; end
    check("issue_ready", 64'(in_ready_v), 64'd3);
    fun = f; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((pending[0] || pending[1]) && t < 30) begin @(posedge clk); #1; t++; end
    check("idle_after_op", 64'(in_ready_v), 64'd3);
  endtask

  task automatic op_lit(input string name, input logic [1:0] f, input logic [63:0] x,
                        input logic [63:0] y, input logic [63:0] er, input logic [2:0] ecc);
    issue(f, x, y);
    wait_done();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_res%0d", name, d), result_v[d], er);
      check($sformatf("%s_cc%0d", name, d), 64'(cc_v[d]), 64'(ecc));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fun = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("init_out_valid%0d", d), 64'(out_valid_v[d]), 64'd0);
      check($sformatf("init_result%0d", d), result_v[d], 64'd0);
      check($sformatf("init_cc%0d", d), 64'(cc_v[d]), 64'd0);
      check($sformatf("init_in_ready%0d", d), 64'(in_ready_v[d]), 64'd1);
    end

    op_lit("add_carry", 2'b00, 64'h0000_0000_0000_FFFF, 64'd1, 64'h1_0000, 3'b000);
    op_lit("add_ovf",   2'b00, 64'h7FFF_FFFF_FFFF_FFFE, 64'd2, 64'h8000_0000_0000_0000, 3'b011);
    op_lit("sub_ovf",   2'b01, 64'h8000_0000_0000_0002, 64'd3, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001);
    op_lit("sub_zero",  2'b01, 64'd587619328768, 64'd587619328768, 64'd0, 3'b100);
    op_lit("add_negov", 2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001);
    op_lit("and_sign",  2'b10, 64'hFFFF_0000_FFFF_0000, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 3'b010);

    // Backpressure: hold out_ready low with a competing request on the input.
    out_ready = 1'b0;
    issue(2'b00, 64'd5, 64'd7);
    t = 0;
    while (out_valid_v != 2'b11 && t < 20) begin @(posedge clk); #1; t++; end
    fun = 2'b11; a = 64'd1; b = 64'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid_v), 64'd3);
      check("bp_in_ready", 64'(in_ready_v), 64'd0);
      check("bp_result16", result_v[0], 64'd12);
      check("bp_result64", result_v[1], 64'd12);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(out_valid_v), 64'd0);
    check("bp_release_ready", 64'(in_ready_v), 64'd3);

    // Reset during the second BUSY cycle of the CHUNK=16 instance.
    issue(2'b00, 64'h1234, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 64'(out_valid_v), 64'd0);
    end
    op_lit("xor_after_rst", 2'b11, 64'hF0F0, 64'hFFFF, 64'h0F0F, 3'b000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
